rf_mp_sb: RTL and testbench

Parametrised multi-port register file with a per-register busy scoreboard, for the next datapath revision. It has NRP read ports and NWP write ports. Writes can be forwarded to same-cycle reads, and register 0 can be hardwired to zero. A busy bit per register is set when an instruction issues to it and cleared when its result is written. Each read port reports whether its operand is ready, so the issue stage can stall without an external scoreboard.

---
 rtl/rf_mp_pkg.sv | 24 ++
 rtl/rf_wdec.sv | 36 +++
 rtl/rf_mp_sb.sv | 94 +++++++++
 tb/tb_rf_mp_sb.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_mp_pkg.sv
// Shared helpers for the multi-port register file: address decode and busy-bit counting.
// Both functions work at the maximum supported size; callers cast the result to their own size.
package rf_mp_pkg;

    localparam int NR_MAX = 256;
    localparam int AW_MAX = 8;

    function automatic logic [NR_MAX-1:0] onehot_dec(input logic [AW_MAX-1:0] addr, input logic en);
        logic [NR_MAX-1:0] v;
        v       = '0;
        v[addr] = en;
        return v;
    endfunction

    function automatic logic [AW_MAX:0] popcount(input logic [NR_MAX-1:0] vec);
        logic [AW_MAX:0] cnt;
        cnt = '0;
        for (int k = 0; k < NR_MAX; k++) begin
            cnt = cnt + (AW_MAX + 1)'(vec[k]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rf_wdec.sv
// Write-port decoder: per-register write enable plus the index of the port that wins.
// The highest-numbered port is applied last, so it owns any address shared with lower ports.
module rf_wdec
    import rf_mp_pkg::*;
#(
    parameter  int AW  = 4,
    parameter  int NWP = 2,
    localparam int NR  = 1 << AW,
    localparam int PW  = (NWP > 1) ? $clog2(NWP) : 1
) (
    input  logic [NWP-1:0]    i_we,
    input  logic [NWP*AW-1:0] i_wa,
    output logic [NR-1:0]     o_wen,
    output logic [NR*PW-1:0]  o_wsel
);

    logic [NR-1:0] w_oh [NWP];

    for (genvar j = 0; j < NWP; j++) begin : g_dec
        assign w_oh[j] = NR'(onehot_dec(AW_MAX'(i_wa[j*AW +: AW]), i_we[j]));
    end

    always_comb begin
        o_wen  = '0;
        o_wsel = '0;
        for (int j = 0; j < NWP; j++) begin
            for (int r = 0; r < NR; r++) begin
                if (w_oh[j][r]) begin
                    o_wen[r]            = 1'b1;
                    o_wsel[r*PW +: PW]  = PW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/rf_mp_sb.sv
// Multi-port register file with a per-register busy scoreboard and optional write bypass.
// Read ports report operand readiness so the issue stage can stall without its own scoreboard.
module rf_mp_sb
    import rf_mp_pkg::*;
#(
    parameter  int BW      = 8,
    parameter  int AW      = 4,
    parameter  int NRP     = 2,
    parameter  int NWP     = 2,
    parameter  int ZERO_R0 = 1,
    parameter  int BYPASS  = 1,
    localparam int NR      = 1 << AW,
    localparam int PW      = (NWP > 1) ? $clog2(NWP) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NRP*AW-1:0] i_ra,
    output logic [NRP*BW-1:0] o_rdat,
    output logic [NRP-1:0]    o_rrdy,
    input  logic [NWP-1:0]    i_we,
    input  logic [NWP*AW-1:0] i_wa,
    input  logic [NWP*BW-1:0] i_wd,
    input  logic              i_iss_v,
    input  logic [AW-1:0]     i_iss_rd,
    output logic [AW:0]       o_nbusy
);

    logic [BW-1:0]    r_mem [NR];
    logic [NR-1:0]    r_busy;
    logic [AW:0]      r_nbusy;

    logic [NR-1:0]    w_wen_raw;
    logic [NR-1:0]    w_wen;
    logic [NR*PW-1:0] w_wsel;
    logic [NR-1:0]    w_r0mask;
    logic [NR-1:0]    w_set;
    logic [NR-1:0]    w_busy_nxt;
    logic [BW-1:0]    w_wdv [NWP];

    rf_wdec #(
        .AW  (AW),
        .NWP (NWP)
    ) u_wdec (
        .i_we   (i_we),
        .i_wa   (i_wa),
        .o_wen  (w_wen_raw),
        .o_wsel (w_wsel)
    );

    for (genvar j = 0; j < NWP; j++) begin : g_wd
        assign w_wdv[j] = i_wd[j*BW +: BW];
    end

    // With a hardwired R0, it can neither be written nor become busy.
    assign w_r0mask   = (ZERO_R0 != 0) ? NR'(1) : '0;
    assign w_wen      = w_wen_raw & ~w_r0mask;
    assign w_set      = NR'(onehot_dec(AW_MAX'(i_iss_rd), i_iss_v)) & ~w_r0mask;
    assign w_busy_nxt = w_set | (r_busy & ~w_wen);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int r = 0; r < NR; r++) begin
                r_mem[r] <= '0;
            end
            r_busy  <= '0;
            r_nbusy <= '0;
        end else begin
            for (int r = 0; r < NR; r++) begin
                if (w_wen[r]) begin
                    r_mem[r] <= w_wdv[w_wsel[r*PW +: PW]];
                end
            end
            r_busy  <= w_busy_nxt;
            r_nbusy <= (AW + 1)'(popcount(NR_MAX'(w_busy_nxt)));
        end
    end

    for (genvar i = 0; i < NRP; i++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_hit;
        logic          w_zero;

        assign w_ra   = i_ra[i*AW +: AW];
        assign w_zero = (ZERO_R0 != 0) && (w_ra == '0);
        assign w_hit  = (BYPASS != 0) && w_wen[w_ra];

        assign o_rdat[i*BW +: BW] = w_zero ? '0
                                  : (w_hit ? w_wdv[w_wsel[w_ra*PW +: PW]] : r_mem[w_ra]);
        assign o_rrdy[i]          = !r_busy[w_ra] || w_hit || w_zero;
    end

    assign o_nbusy = r_nbusy;

endmodule

// File: tb/tb_rf_mp_sb.sv
// Self-checking bench for rf_mp_sb: directed scenarios followed by random traffic,
// all compared against a plain array model of registers and busy flags.
module tb_rf_mp_sb;

    localparam int BW  = 8;
    localparam int AW  = 4;
    localparam int NR  = 16;
    localparam int NRP = 2;
    localparam int NWP = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NRP*AW-1:0] ra;
    logic [NRP*BW-1:0] rdat;
    logic [NRP-1:0]    rrdy;
    logic [NWP-1:0]    we;
    logic [NWP*AW-1:0] wa;
    logic [NWP*BW-1:0] wd;
    logic              iss_v;
    logic [AW-1:0]     iss_rd;
    logic [AW:0]       nbusy;

    int compared   = 0;
    int mismatched = 0;

    logic [BW-1:0] mMem [NR];
    bit            mBusy [NR];

    always #5 clk = ~clk;

    rf_mp_sb #(
        .BW      (BW),
        .AW      (AW),
        .NRP     (NRP),
        .NWP     (NWP),
        .ZERO_R0 (1),
        .BYPASS  (1)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_ra     (ra),
        .o_rdat   (rdat),
        .o_rrdy   (rrdy),
        .i_we     (we),
        .i_wa     (wa),
        .i_wd     (wd),
        .i_iss_v  (iss_v),
        .i_iss_rd (iss_rd),
        .o_nbusy  (nbusy)
    );

    function automatic logic writesTo(int a);
        for (int j = 0; j < NWP; j++) begin
            if (we[j] && int'(wa[j*AW +: AW]) == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [BW-1:0] expData(int p);
        int            a;
        logic [BW-1:0] v;
        a = int'(ra[p*AW +: AW]);
        if (a == 0) return '0;
        v = mMem[a];
        for (int j = 0; j < NWP; j++) begin
            if (we[j] && int'(wa[j*AW +: AW]) == a) v = wd[j*BW +: BW];
        end
        return v;
    endfunction

    function automatic logic expRdy(int p);
        int a;
        a = int'(ra[p*AW +: AW]);
        return (a == 0) || !mBusy[a] || writesTo(a);
    endfunction

    function automatic int expNbusy();
        int n;
        n = 0;
        for (int r = 0; r < NR; r++) n += int'(mBusy[r]);
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        for (int p = 0; p < NRP; p++) begin
            check($sformatf("%s_rdat%0d", tag, p), 32'(rdat[p*BW +: BW]), 32'(expData(p)));
            check($sformatf("%s_rrdy%0d", tag, p), 32'(rrdy[p]), 32'(expRdy(p)));
        end
        check($sformatf("%s_nbusy", tag), 32'(nbusy), 32'(expNbusy()));
    endtask

    task automatic modelEdge();
        bit nb [NR];
        bit set, clr;
        if (rst) begin
            for (int r = 0; r < NR; r++) begin
                mMem[r]  = '0;
                mBusy[r] = 1'b0;
            end
        end else begin
            for (int r = 0; r < NR; r++) begin
                set   = iss_v && int'(iss_rd) == r && r != 0;
                clr   = writesTo(r);
                nb[r] = set ? 1'b1 : (clr ? 1'b0 : mBusy[r]);
            end
            for (int j = 0; j < NWP; j++) begin
                if (we[j] && wa[j*AW +: AW] != '0) mMem[wa[j*AW +: AW]] = wd[j*BW +: BW];
            end
            for (int r = 0; r < NR; r++) mBusy[r] = nb[r];
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] a0, input logic [3:0] a1,
                                 input logic [1:0] w, input logic [3:0] wa0, input logic [3:0] wa1,
                                 input logic [7:0] d0, input logic [7:0] d1,
                                 input logic iv, input logic [3:0] ird);
        rst    = r;
        ra     = {a1, a0};
        we     = w;
        wa     = {wa1, wa0};
        wd     = {d1, d0};
        iss_v  = iv;
        iss_rd = ird;
    endtask

    task automatic settle(input string tag);
        #2;
        checkOutput(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    initial begin
        applyStimulus(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        tick();

        applyStimulus(0, 5, 9, 2'b00, 0, 0, 0, 0, 0, 0);
        settle("reset_read");
        check("reset_rdat", 32'(rdat), 32'(0));
        check("reset_rrdy", 32'(rrdy), 32'(2'b11));
        check("reset_nbusy", 32'(nbusy), 32'(0));
        tick();

        applyStimulus(0, 3, 0, 2'b01, 3, 0, 8'hA5, 0, 0, 0);
        settle("wr_bypass");
        check("wr_bypass_val", 32'(rdat[7:0]), 32'(8'hA5));
        tick();
        applyStimulus(0, 3, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        settle("wr_stored");
        check("wr_stored_val", 32'(rdat[7:0]), 32'(8'hA5));
        tick();

        applyStimulus(0, 7, 3, 2'b11, 7, 7, 8'h11, 8'h22, 0, 0);
        settle("conflict_bypass");
        check("conflict_bypass_val", 32'(rdat[7:0]), 32'(8'h22));
        tick();
        applyStimulus(0, 7, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        settle("conflict_stored");
        check("conflict_stored_val", 32'(rdat[7:0]), 32'(8'h22));
        tick();

        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 4);
        settle("issue4");
        tick();
        applyStimulus(0, 4, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        settle("busy4");
        check("busy4_rrdy", 32'(rrdy[0]), 32'(0));
        check("busy4_nbusy", 32'(nbusy), 32'(1));
        tick();
        applyStimulus(0, 4, 0, 2'b01, 4, 0, 8'h3C, 0, 0, 0);
        settle("commit4");
        check("commit4_rrdy", 32'(rrdy[0]), 32'(1));
        check("commit4_rdat", 32'(rdat[7:0]), 32'(8'h3C));
        tick();
        applyStimulus(0, 4, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        settle("after4");
        check("after4_nbusy", 32'(nbusy), 32'(0));
        tick();

        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 6);
        settle("issue6");
        tick();
        applyStimulus(0, 6, 0, 2'b01, 6, 0, 8'h5A, 0, 1, 6);
        settle("collide6");
        tick();
        applyStimulus(0, 6, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        settle("after6");
        check("after6_rdat", 32'(rdat[7:0]), 32'(8'h5A));
        check("after6_rrdy", 32'(rrdy[0]), 32'(0));
        check("after6_nbusy", 32'(nbusy), 32'(1));
        tick();

        applyStimulus(0, 0, 6, 2'b01, 0, 0, 8'hFF, 0, 1, 0);
        settle("r0_write");
        check("r0_write_rdat", 32'(rdat[7:0]), 32'(0));
        check("r0_write_rrdy", 32'(rrdy[0]), 32'(1));
        tick();
        applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1);
        settle("r0_after");
        check("r0_after_rdat", 32'(rdat[7:0]), 32'(0));
        check("r0_after_nbusy", 32'(nbusy), 32'(1));
        tick();
        applyStimulus(0, 1, 2, 2'b00, 0, 0, 0, 0, 1, 2);
        settle("issue2");
        tick();
        applyStimulus(1, 6, 7, 2'b11, 8, 9, 8'h44, 8'h55, 1, 10);
        settle("busy3_rst");
        check("busy3_nbusy", 32'(nbusy), 32'(3));
        tick();
        applyStimulus(0, 6, 7, 2'b00, 0, 0, 0, 0, 0, 0);
        settle("post_rst");
        check("post_rst_nbusy", 32'(nbusy), 32'(0));
        check("post_rst_rdat", 32'(rdat), 32'(0));
        tick();

        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 63) == 0),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          2'($urandom_range(0, 3)),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          8'($urandom), 8'($urandom),
                          ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)));
            settle($sformatf("rand%0d", n));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
